// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle control FSM and the 16-bit datapath around it.
// The datapath side (master) supplies IR, the branch condition and the memory
// handshake. The control side (slave) drives every strobe and mux select.
interface multicycle_control_if;
    logic [15:0] Instr;
    logic        Perform;
    logic        MemReady;
    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        IorD;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        MemToReg;
    logic [1:0]  PCSrc;
    logic [2:0]  ALUOp;
    logic        FU;
    logic [3:0]  Op;
    logic [2:0]  CC;
    logic        Halted;
    logic        Illegal;

    modport master (
        output Instr, Perform, MemReady,
        input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, ALUSrcA,
               ALUSrcB, MemToReg, PCSrc, ALUOp, FU, Op, CC, Halted, Illegal
    );

    modport slave (
        input  Instr, Perform, MemReady,
        output PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, ALUSrcA,
               ALUSrcB, MemToReg, PCSrc, ALUOp, FU, Op, CC, Halted, Illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB/BRANCH/HALT sequencing,
// memory ready-handshake with a bounded wait, and sticky illegal/timeout halt.
module multicycle_control #(
    parameter int WAIT_LIMIT = 8
) (
    input logic                 CLK,
    input logic                 Reset,
    multicycle_control_if.slave bus
);
    localparam int WW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

    localparam logic [3:0] OP_ADD  = 4'b0000, OP_ADDI = 4'b0001, OP_AND = 4'b0010,
                           OP_OR   = 4'b0011, OP_SUB  = 4'b0100, OP_CMP = 4'b0101,
                           OP_SLL  = 4'b0110, OP_SRL  = 4'b0111, OP_LW  = 4'b1000,
                           OP_SW   = 4'b1001, OP_BR   = 4'b1010, OP_LUI = 4'b1100,
                           OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            illegal_q, illegal_d;
    logic [3:0]      op;
    logic            waiting, timeout;
    logic            unused_imm;

    assign op         = bus.Instr[15:12];
    assign unused_imm = ^bus.Instr[8:0];
    assign bus.Op     = op;
    assign bus.Halted = (state_q == S_HALT);
    assign bus.Illegal = illegal_q;

    // A wait cycle is a FETCH/MEM cycle without MemReady; the last allowed one times out.
    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.MemReady;
    assign timeout = waiting && (wait_q == WW'(WAIT_LIMIT - 1));

    // State, wait counter and sticky illegal flag; reset aborts everything at once.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state and control outputs; everything is held quiet while Reset is high.
    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        wait_d        = '0;
        bus.PCWrite   = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IorD      = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.MemToReg  = 1'b0;
        bus.PCSrc     = 2'b00;
        bus.ALUOp     = 3'b000;
        bus.FU        = 1'b0;
        bus.CC        = 3'b111;
        if (!Reset) begin
            if (waiting && !timeout) wait_d = wait_q + WW'(1);
            case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    if (bus.MemReady) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        state_d     = S_DECODE;
                    end else if (timeout) begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                end
                S_DECODE: begin
                    // Precompute branch target PC + sext(imm) into ALUOut.
                    bus.ALUSrcB = 2'b11;
                    case (op)
                        OP_BR:   state_d = S_BRANCH;
                        OP_HALT: state_d = S_HALT;
                        4'b1011, 4'b1101, 4'b1110: begin
                            illegal_d = 1'b1;
                            state_d   = S_HALT;
                        end
                        default: state_d = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = (op == OP_ADDI || op == OP_LW || op == OP_SW || op == OP_LUI)
                                  ? 2'b10 : 2'b00;
                    case (op)
                        OP_AND:         bus.ALUOp = 3'b001;
                        OP_SUB, OP_CMP: bus.ALUOp = 3'b010;
                        OP_OR:          bus.ALUOp = 3'b011;
                        OP_SLL:         bus.ALUOp = 3'b100;
                        OP_SRL:         bus.ALUOp = 3'b101;
                        OP_LUI:         bus.ALUOp = 3'b110;
                        default:        bus.ALUOp = 3'b000;
                    endcase
                    bus.FU = (op <= OP_SRL);
                    if (op == OP_LW || op == OP_SW) state_d = S_MEM;
                    else if (op == OP_CMP)          state_d = S_FETCH;
                    else                            state_d = S_WB;
                end
                S_MEM: begin
                    bus.IorD     = 1'b1;
                    bus.MemRead  = (op == OP_LW);
                    bus.MemWrite = (op != OP_LW);
                    if (bus.MemReady) begin
                        state_d = (op == OP_LW) ? S_WB : S_FETCH;
                    end else if (timeout) begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                end
                S_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemToReg = (op == OP_LW);
                    state_d      = S_FETCH;
                end
                S_BRANCH: begin
                    bus.CC = bus.Instr[11:9];
                    if (bus.Perform) begin
                        bus.PCWrite = 1'b1;
                        bus.PCSrc   = 2'b01;
                    end
                    state_d = S_FETCH;
                end
                default: state_d = S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected control vectors are pushed to
// a scoreboard as each step is driven and popped when the outputs are sampled.
module tb_multicycle_control;
    typedef struct packed {
        logic       pcw, irw, rw, mrd, mwr, iord, srca;
        logic [1:0] srcb;
        logic       m2r;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       fu;
        logic [3:0] op;
        logic [2:0] cc;
        logic       halted, illegal;
    } ctl_t;

    logic CLK = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    ctl_t sb[$];

    multicycle_control_if ifc ();
    multicycle_control #(.WAIT_LIMIT(8)) dut (.CLK(CLK), .Reset(Reset), .bus(ifc));

    always #5 CLK = ~CLK;

    function automatic ctl_t e_base(input logic [3:0] op);
        ctl_t e = '0;
        e.op = op;
        e.cc = 3'b111;
        return e;
    endfunction

    function automatic ctl_t e_fetch(input logic [3:0] op, input logic rdy);
        ctl_t e = e_base(op);
        e.mrd = 1'b1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy;
        return e;
    endfunction

    function automatic ctl_t e_decode(input logic [3:0] op);
        ctl_t e = e_base(op);
        e.srcb = 2'b11;
        return e;
    endfunction

    function automatic ctl_t e_exec(input logic [3:0] op, input logic [1:0] srcb,
                                    input logic [2:0] aluop, input logic fu);
        ctl_t e = e_base(op);
        e.srca = 1'b1; e.srcb = srcb; e.aluop = aluop; e.fu = fu;
        return e;
    endfunction

    function automatic ctl_t e_mem(input logic [3:0] op, input logic lw);
        ctl_t e = e_base(op);
        e.iord = 1'b1; e.mrd = lw; e.mwr = !lw;
        return e;
    endfunction

    function automatic ctl_t e_wb(input logic [3:0] op, input logic m2r);
        ctl_t e = e_base(op);
        e.rw = 1'b1; e.m2r = m2r;
        return e;
    endfunction

    function automatic ctl_t e_branch(input logic [3:0] op, input logic [2:0] cc, input logic p);
        ctl_t e = e_base(op);
        e.cc = cc; e.pcw = p; e.pcsrc = p ? 2'b01 : 2'b00;
        return e;
    endfunction

    function automatic ctl_t e_halt(input logic [3:0] op, input logic ill);
        ctl_t e = e_base(op);
        e.halted = 1'b1; e.illegal = ill;
        return e;
    endfunction

    // Push expectation, let combinational outputs settle, pop and compare.
    task automatic chk(input string tag, input ctl_t exp);
        ctl_t obs, want;
        sb.push_back(exp);
        #1;
        obs = {ifc.PCWrite, ifc.IRWrite, ifc.RegWrite, ifc.MemRead, ifc.MemWrite,
               ifc.IorD, ifc.ALUSrcA, ifc.ALUSrcB, ifc.MemToReg, ifc.PCSrc,
               ifc.ALUOp, ifc.FU, ifc.Op, ifc.CC, ifc.Halted, ifc.Illegal};
        want = sb.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // One full cycle: check at the current negedge, then move to the next one.
    task automatic cyc(input string tag, input ctl_t exp);
        chk(tag, exp);
        @(negedge CLK);
    endtask

    initial begin
        Reset = 1'b1;
        ifc.Instr = 16'h0000;
        ifc.Perform = 1'b0;
        ifc.MemReady = 1'b0;
        @(negedge CLK);
        cyc("reset", e_base(4'h0));
        Reset = 1'b0;

        // ADD: FETCH, DECODE, EXEC, WB, then FETCH
        ifc.Instr = 16'h0123; ifc.MemReady = 1'b1;
        cyc("add_fetch", e_fetch(4'h0, 1'b1));
        cyc("add_decode", e_decode(4'h0));
        cyc("add_exec", e_exec(4'h0, 2'b00, 3'b000, 1'b1));
        cyc("add_wb", e_wb(4'h0, 1'b0));

        // CMP: flags only, straight back to FETCH
        ifc.Instr = 16'h5040;
        cyc("cmp_fetch", e_fetch(4'h5, 1'b1));
        cyc("cmp_decode", e_decode(4'h5));
        cyc("cmp_exec", e_exec(4'h5, 2'b00, 3'b010, 1'b1));

        // BR not taken, then taken
        ifc.Instr = 16'hA400;
        cyc("br0_fetch", e_fetch(4'hA, 1'b1));
        cyc("br0_decode", e_decode(4'hA));
        ifc.Perform = 1'b0;
        cyc("br0_branch", e_branch(4'hA, 3'b010, 1'b0));
        cyc("br1_fetch", e_fetch(4'hA, 1'b1));
        cyc("br1_decode", e_decode(4'hA));
        ifc.Perform = 1'b1;
        cyc("br1_branch", e_branch(4'hA, 3'b010, 1'b1));
        ifc.Perform = 1'b0;

        // LW with three wait cycles in MEM
        ifc.Instr = 16'h8005;
        cyc("lw_fetch", e_fetch(4'h8, 1'b1));
        cyc("lw_decode", e_decode(4'h8));
        cyc("lw_exec", e_exec(4'h8, 2'b10, 3'b000, 1'b0));
        ifc.MemReady = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", e_mem(4'h8, 1'b1));
        ifc.MemReady = 1'b1;
        cyc("lw_mem_done", e_mem(4'h8, 1'b1));
        cyc("lw_wb", e_wb(4'h8, 1'b1));

        // SW interrupted by an asynchronous reset while in MEM
        ifc.Instr = 16'h9003;
        cyc("sw_fetch", e_fetch(4'h9, 1'b1));
        cyc("sw_decode", e_decode(4'h9));
        cyc("sw_exec", e_exec(4'h9, 2'b10, 3'b000, 1'b0));
        ifc.MemReady = 1'b0;
        chk("sw_mem", e_mem(4'h9, 1'b0));
        #2 Reset = 1'b1;
        chk("sw_async_reset", e_base(4'h9));
        @(negedge CLK);
        Reset = 1'b0;
        cyc("post_reset_fetch", e_fetch(4'h9, 1'b0));

        // Illegal opcode 1101 halts after DECODE and stays halted
        ifc.Instr = 16'hD000; ifc.MemReady = 1'b1;
        cyc("ill_fetch", e_fetch(4'hD, 1'b1));
        cyc("ill_decode", e_decode(4'hD));
        cyc("ill_halt", e_halt(4'hD, 1'b1));
        cyc("ill_halt_hold", e_halt(4'hD, 1'b1));

        // Reset clears the halt, then FETCH times out after WAIT_LIMIT waits
        Reset = 1'b1;
        chk("halt_reset", e_base(4'hD));
        @(negedge CLK);
        Reset = 1'b0;
        ifc.Instr = 16'h0000; ifc.MemReady = 1'b0;
        for (int i = 0; i < 8; i++) cyc("to_wait", e_fetch(4'h0, 1'b0));
        cyc("to_halt", e_halt(4'h0, 1'b1));
        ifc.MemReady = 1'b1;
        cyc("to_halt_hold", e_halt(4'h0, 1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
